// File: rtl/collision_event_handler.sv
// ============================================================================
// collision_event_handler
//
// Purpose:
//   Consumes the per-pixel collision vector from the collision detector and
//   ORs it into a per-frame accumulator. At each frame boundary it publishes
//   one registered event vector. It also runs the game-level reaction:
//   lives, score, the invulnerability window after a lost life, and
//   game-over.
//
// Optional feature (macro COLLISION_EDGE_EN):
//   When the macro is defined, the block remembers the previous raw frame
//   vector. It reports only contacts that were absent in that frame, so a
//   contact that persists across frames is reported once. When the macro is
//   undefined, every frame that contains a contact reports it.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   startOfFrame  one-cycle pulse at frame start
//   startGame     one-cycle request to begin or restart a game
//   collision     raw collision bits (bit0 player/monsterMissile,
//                 bit1 player/monster, bit2 monster/playerMissile,
//                 bits3..5 shield pairs, bits6..9 border pairs)
//   frameEvents   collisions that occurred during the previous frame
//   eventValid    one-cycle pulse: frameEvents updated and nonzero
//   lives         remaining lives
//   score         current score (saturating)
//   invulnerable  high while in state INVULN
//   gameOver      high while in state OVER
// ============================================================================
module collision_event_handler #(
  parameter int NUM_COLL      = 10,
  parameter int LIVES_INIT    = 3,
  parameter int LIVES_W       = 3,
  parameter int SCORE_W       = 12,
  parameter int SCORE_PER_HIT = 10,
  parameter int INVULN_FRAMES = 60
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                startOfFrame,
  input  logic                startGame,
  input  logic [NUM_COLL-1:0] collision,
  output logic [NUM_COLL-1:0] frameEvents,
  output logic                eventValid,
  output logic [LIVES_W-1:0]  lives,
  output logic [SCORE_W-1:0]  score,
  output logic                invulnerable,
  output logic                gameOver
);

  localparam int CNT_W = $clog2(INVULN_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    INVULN,
    OVER
  } stateT;

  stateT               state;
  stateT               stateNext;
  logic [NUM_COLL-1:0] accum;
  logic [NUM_COLL-1:0] rawFrame;
  logic [NUM_COLL-1:0] newFrame;
  logic [CNT_W-1:0]    invulnCnt;
  logic [CNT_W-1:0]    invulnCntNext;
  logic [LIVES_W-1:0]  livesNext;
  logic [SCORE_W-1:0]  scoreNext;
  logic [SCORE_W:0]    scoreSum;
  logic [SCORE_W-1:0]  scoreSat;
  logic                playerHit;
  logic                monsterHit;

  // The frame vector includes the collision bits of the startOfFrame cycle
  // itself, so a contact seen on the boundary cycle still counts toward the
  // frame that is closing.
  assign rawFrame = accum | collision;

`ifdef COLLISION_EDGE_EN
  logic [NUM_COLL-1:0] prevFrame;

  // Remember the unfiltered vector of the frame that just closed. The next
  // frame then reports only contacts that were absent from it.
  always_ff @(posedge clk) begin
    if (reset) begin
      prevFrame <= '0;
    end else if (startOfFrame) begin
      prevFrame <= rawFrame;
    end
  end

  assign newFrame = rawFrame & ~prevFrame;
`else
  assign newFrame = rawFrame;
`endif

  // The game reaction is driven by the same vector that is published on
  // frameEvents. In edge mode, a held contact therefore neither scores nor
  // costs a life again.
  assign playerHit  = newFrame[0] | newFrame[1];
  assign monsterHit = newFrame[2];

  // The sum is one bit wider than the score, so an overflow shows up in the
  // top bit. In that case the score clamps to all ones instead of wrapping.
  assign scoreSum = {1'b0, score} + (SCORE_W + 1)'(SCORE_PER_HIT);
  assign scoreSat = scoreSum[SCORE_W] ? '1 : scoreSum[SCORE_W-1:0];

  // Frame accumulator and the published event vector. Between boundaries,
  // collisions are ORed in. On a boundary, the closing frame is published
  // and the accumulator restarts from zero. Reset discards any partially
  // collected frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      accum       <= '0;
      frameEvents <= '0;
      eventValid  <= 1'b0;
    end else if (startOfFrame) begin
      accum       <= '0;
      frameEvents <= newFrame;
      eventValid  <= |newFrame;
    end else begin
      accum      <= rawFrame;
      eventValid <= 1'b0;
    end
  end

  // Game state register. Lives, score and the invulnerability counter move
  // together with the state, so every reaction shows up one clock after the
  // startOfFrame cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lives     <= LIVES_W'(LIVES_INIT);
      score     <= '0;
      invulnCnt <= '0;
    end else begin
      state     <= stateNext;
      lives     <= livesNext;
      score     <= scoreNext;
      invulnCnt <= invulnCntNext;
    end
  end

  // Next-state logic for the game. A startGame request has priority over
  // the frame boundary in every state. It reloads lives and clears score
  // and the counter, so the events of that frame are not applied. On a
  // boundary in PLAY, a monster hit scores and a player hit costs a life.
  // When the player and monster hits land in the same frame, both take
  // effect at the same edge. INVULN keeps scoring but ignores player hits
  // while it counts down the remaining boundaries. IDLE and OVER leave
  // lives and score untouched.
  always_comb begin
    stateNext     = state;
    livesNext     = lives;
    scoreNext     = score;
    invulnCntNext = invulnCnt;

    if (startGame) begin
      stateNext     = PLAY;
      livesNext     = LIVES_W'(LIVES_INIT);
      scoreNext     = '0;
      invulnCntNext = '0;
    end else if (startOfFrame) begin
      case (state)
        PLAY: begin
          if (monsterHit) begin
            scoreNext = scoreSat;
          end
          if (playerHit) begin
            if (lives > LIVES_W'(1)) begin
              livesNext     = lives - LIVES_W'(1);
              invulnCntNext = CNT_W'(INVULN_FRAMES);
              stateNext     = INVULN;
            end else begin
              livesNext = '0;
              stateNext = OVER;
            end
          end
        end
        INVULN: begin
          if (monsterHit) begin
            scoreNext = scoreSat;
          end
          invulnCntNext = invulnCnt - CNT_W'(1);
          if (invulnCnt == CNT_W'(1)) begin
            stateNext = PLAY;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The status flags decode the registered state directly. They change on
  // the same edge as the state.
  assign invulnerable = (state == INVULN);
  assign gameOver     = (state == OVER);

endmodule

// File: doc/collision_event_handler.md
Name: collision_event_handler

Overview:
- Sequential consumer of the 10-bit per-pixel collision vector produced by the collision detector.
- Accumulates collisions over each video frame and publishes one registered event vector per frame.
- Runs the game-level reaction: lives, score, invulnerability window and game-over.
- Sits between the collision detector and the score/lives display and object controllers.

Parameters:
- NUM_COLL, 10, width of collision vector.
- LIVES_INIT, 3, lives loaded on reset/game start (1..7).
- LIVES_W, 3, width of lives output.
- SCORE_W, 12, width of score output.
- SCORE_PER_HIT, 10, points added per frame with a monster hit.
- INVULN_FRAMES, 60, frames of player invulnerability after losing a life (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at frame start.
- startGame  in  1  one-cycle request to begin or restart a game.
- collision  in  NUM_COLL  raw collision bits. bit0 player/monsterMissile, bit1 player/monster, bit2 monster/playerMissile, bit3..5 shield pairs, bit6..9 border pairs.
- frameEvents  out  NUM_COLL  collisions that occurred during the previous frame.
- eventValid  out  1  one-cycle pulse: frameEvents updated and nonzero.
- lives  out  LIVES_W  remaining lives.
- score  out  SCORE_W  current score.
- invulnerable  out  1  high while in state INVULN.
- gameOver  out  1  high while in state OVER.

Behaviour:
- Reset (sync, highest priority) sets outputs and state as follows:
  - frameEvents=0, eventValid=0, lives=LIVES_INIT, score=0, invulnerable=0, gameOver=0.
  - accumulator=0, invulnCnt=0, state=IDLE.
- Accumulator, on cycles without startOfFrame: accum <= accum | collision.
- On a startOfFrame cycle:
  - frameEvents <= accum | collision, so the current cycle is included.
  - accum <= 0.
  - eventValid <= |(accum | collision).
- eventValid is high only for the cycle after startOfFrame; it is 0 otherwise.
- Derived flags, taken from the new frame vector at the same edge:
  - playerHit = bit0 | bit1.
  - monsterHit = bit2.
- FSM states: IDLE, PLAY, INVULN, OVER. All transitions are registered.
  - IDLE: frame events are ignored for lives and score. startGame -> PLAY, with lives=LIVES_INIT and score=0.
  - PLAY, on startOfFrame:
    - monsterHit: score += SCORE_PER_HIT, saturating at 2^SCORE_W-1.
    - playerHit with lives>1: lives -= 1, invulnCnt=INVULN_FRAMES, -> INVULN.
    - playerHit with lives==1: lives=0, -> OVER.
  - INVULN:
    - playerHit is ignored; monsterHit still scores.
    - On each startOfFrame invulnCnt decrements; a startOfFrame seen with invulnCnt==1 -> PLAY.
    - The block therefore stays INVULN for exactly INVULN_FRAMES frame boundaries.
  - OVER: score and lives are frozen. startGame -> PLAY, with lives=LIVES_INIT and score=0.
- Simultaneous events:
  - monsterHit and playerHit in the same frame: score is updated and the life is lost at the same edge.
  - startGame and startOfFrame in the same cycle: startGame wins and that frame's events do not affect lives or score. frameEvents and eventValid still update normally.
  - startGame in PLAY or INVULN: restart to PLAY with reload; invulnCnt=0.
- Reset mid-frame discards partially accumulated collisions.
- Latency: events are visible on frameEvents, lives and score 1 clk after the startOfFrame cycle.

Optional Feature:
- Macro: COLLISION_EDGE_EN.
- Defined:
  - The block keeps prevFrame, the previous raw frame vector.
  - frameEvents = raw & ~prevFrame, so only new contacts are reported; a contact persisting across frames is reported once.
  - eventValid, score and lives use this filtered vector.
  - prevFrame resets to 0.
- Undefined: level behaviour as described above; every frame containing a contact reports it.

Test Plan:
- Reset, then 3 frames with no collision -> frameEvents=0, eventValid never high, lives=3, score=0, state IDLE.
- startGame, then collision=0x004 pulsed 1 cycle mid-frame -> after next startOfFrame, frameEvents=0x004, eventValid one cycle, score=10.
- In PLAY, collision bit0 in frame N -> lives=2, invulnerable=1.
  - bit0 again in each of the next 59 frames -> lives stays 2.
  - After the 60th boundary invulnerable=0; a hit in the following frame -> lives=1.
- lives=1, bit1 and bit2 in the same frame -> score+10 and lives=0, gameOver=1. Further bit2 frames leave score unchanged. startGame -> lives=3, score=0, gameOver=0.
- Score near max (SCORE_W=12, score=4090), monsterHit -> score=4095; another monsterHit -> stays 4095.
- With COLLISION_EDGE_EN, bit2 held across 5 frames -> eventValid once, score +10 only. Without the macro -> eventValid 5 times, score +50.
